tile_scanner: RTL and testbench
===============================

# tile_scanner

Parametrised tile-selection sequencer driving the board's highlighted-tile index. It steps a registered location through `NUM_TILES` positions at a programmable rate using an internal reload divider. It supports up/down direction, a per-tile skip mask, synchronous location load and a freeze (pause) input. It sits between game control (enable/pause/load) and the tile renderer/hit-check logic, which consume `location_out`, `tick` and `wrap`.

## Interface
- `NUM_TILES`, 9: number of tile positions, legal range 2..16.
- `LOC_W`, 4: width of location fields; must satisfy 2^LOC_W >= NUM_TILES.
- `DIV_W`, 7: width of the divider counter and the `period` input.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: run the scanner; when low, the divider is held at reload.
- `pause` in 1: freeze the divider and location.
- `period` in DIV_W: advance interval minus one, in clock cycles.
- `dir` in 1: direction; 0 = ascending, 1 = descending.
- `skip_mask` in NUM_TILES: bit i = 1 removes tile i from the sequence.
- `load` in 1: one-cycle strobe; forces the location to `load_loc`.
- `load_loc` in LOC_W: location to load.
- `bounce` in 1: bounce mode select (present only with `TILE_SCAN_BOUNCE_EN`).
- `location_out` out LOC_W: current tile index, registered.
- `tick` out 1: one-cycle pulse, coincident with an advance.
- `wrap` out 1: one-cycle pulse when an advance wraps past the end.
- `dir_out` out 1: effective direction currently in use.

## Operation
- Divider `cnt[DIV_W-1:0]` is evaluated each cycle in this priority order:
  - reset: `cnt <= period`.
  - load: `cnt <= period`.
  - `!enable`: `cnt <= period`.
  - pause: `cnt` holds.
  - `cnt == 0`: `cnt <= period` and an advance occurs.
  - otherwise: `cnt <= cnt - 1`.
- `period` is sampled only at reload. A change takes effect after the current interval.
- Advance, ascending: new location = first unmasked tile among loc+1 … loc+NUM_TILES-1, taken modulo NUM_TILES. Descending uses the mirror search.
- No other tile unmasked (including the all-masked case): location holds, `tick` still pulses, `wrap` = 0.
- A current tile that has become masked is left on the next advance. It is not left immediately.
- `wrap` = 1 on an advance where the new location < old location (ascending) or new > old (descending).
- Load:
  - `location_out <= load_loc` if `load_loc < NUM_TILES`; otherwise `location_out <= 0`.
  - Works regardless of `enable` and `pause`.
  - No `tick`, no `wrap`.
  - Load wins over a coincident advance.
- Pause holds `location_out` and `cnt`; `tick` and `wrap` stay 0.
- `tick` and `wrap` are registered and change on the same edge as `location_out`.

## Timing
- Reset values: `location_out` = 0, `tick` = 0, `wrap` = 0, `cnt` = `period`, `dir_out` = `dir`.
- With `enable` = 1 and `pause` = 0 after reset or load, the first advance is visible P+1 cycles later, then every P+1 cycles. P = 0 gives an advance every cycle.
- Pause for k cycles stretches the interval in progress by exactly k cycles.
- Reset asserted mid-interval discards any partial count on that edge.
- `dir` changes apply to the next advance. No latency beyond the interval.
- `skip_mask` is sampled combinationally at the advance edge.

## Configuration
- `TILE_SCAN_BOUNCE_EN` defined:
  - Adds the `bounce` input and an internal direction register `bdir`.
  - `bdir` loads from `dir` at reset, on load, and whenever `bounce` = 0.
  - With `bounce` = 1, an advance that finds no unmasked tile beyond the current one in `bdir` (no wrapping) toggles `bdir`. It then moves to the nearest unmasked tile in the new direction.
  - Bounce never asserts `wrap`.
  - `dir_out` = `bdir`.
- Not defined:
  - No `bounce` port and no `bdir` register.
  - Wrap-around only.
  - `dir_out` = `dir`.

## Test plan
- Free-run: reset, `period` = 3, `dir` = 0, mask = 0, 40 cycles → location 0,1,…,8,0 with a change every 4 cycles; `wrap` pulses once, on the 8→0 advance.
- Skip mask: mask = 9'b000100110, `dir` = 0 → sequence 0,3,4,6,7,8,0. With `dir` = 1 from 0 → sequence 8,7,6,4,3,0.
- Pause/load: pause 5 cycles mid-interval → advance delayed by exactly 5 cycles. `load` = 1 with `load_loc` = 12 → `location_out` = 0, no `tick`, next advance P+1 cycles later.
- Degenerate mask: mask = all ones except bit 5, location 5 → `tick` pulses every interval, location stays 5, `wrap` = 0. Mask = all ones → location holds.
- Period change and reset: `period` 3→0 mid-interval → current interval completes at 4 cycles, then advances occur every cycle. `reset` mid-interval → all outputs return to reset values on the next edge.
- Bounce (macro on, `bounce` = 1, mask = 0, P = 0) → 0,1,…,8,7,…,0,1; `dir_out` toggles at 8 and at 0; `wrap` never asserts.

Source files
------------

// File: rtl/tile_scanner.sv
// ---------------------------------------------------------------------------
// tile_scanner
//   Tile-selection sequencer for the board highlight. A reload divider paces
//   advances; each advance moves location_out to the next unmasked tile in
//   the current direction (wrapping), or bouncing at the ends when the
//   optional bounce feature is built in.
//
//   Optional feature macro: TILE_SCAN_BOUNCE_EN
//     defined   -> adds input `bounce` and the bounce direction register;
//                  dir_out reports that register.
//     undefined -> wrap-around only; dir_out follows dir.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   enable        in   run the scanner; low holds the divider at reload
//   pause         in   freeze divider and location
//   period        in   advance interval minus one (sampled at reload)
//   dir           in   0 = ascending, 1 = descending
//   skip_mask     in   bit i set removes tile i from the sequence
//   load          in   one-cycle strobe forcing location to load_loc
//   load_loc      in   location to load (out-of-range loads give 0)
//   bounce        in   bounce mode select (TILE_SCAN_BOUNCE_EN only)
//   location_out  out  current tile index, registered
//   tick          out  one-cycle pulse on every advance
//   wrap          out  one-cycle pulse when an advance wraps past the end
//   dir_out       out  effective direction in use
// ---------------------------------------------------------------------------
module tile_scanner #(
    parameter int NUM_TILES = 9,
    parameter int LOC_W     = 4,
    parameter int DIV_W     = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 pause,
    input  logic [DIV_W-1:0]     period,
    input  logic                 dir,
    input  logic [NUM_TILES-1:0] skip_mask,
    input  logic                 load,
    input  logic [LOC_W-1:0]     load_loc,
`ifdef TILE_SCAN_BOUNCE_EN
    input  logic                 bounce,
`endif
    output logic [LOC_W-1:0]     location_out,
    output logic                 tick,
    output logic                 wrap,
    output logic                 dir_out
);

    // Search for the nearest unmasked tile other than `loc`, stepping in
    // direction `desc`. With `nowrap` set the search stops at the board
    // edge instead of folding modulo NUM_TILES. Returns {found, index}.
    function automatic logic [LOC_W:0] scan(
        input logic [LOC_W-1:0]     loc,
        input logic [NUM_TILES-1:0] mask,
        input logic                 desc,
        input logic                 nowrap
    );
        logic             found;
        logic [LOC_W-1:0] idx;
        int               t;
        found = 1'b0;
        idx   = loc;
        for (int k = 1; k < NUM_TILES; k++) begin
            t = desc ? int'(loc) - k : int'(loc) + k;
            if (!nowrap) begin
                if (t >= NUM_TILES)
                    t = t - NUM_TILES;
                else if (t < 0)
                    t = t + NUM_TILES;
            end
            if (!found && t >= 0 && t < NUM_TILES) begin
                if ((mask & (NUM_TILES'(1) << t)) == '0) begin
                    found = 1'b1;
                    idx   = LOC_W'(t);
                end
            end
        end
        return {found, idx};
    endfunction

    logic [DIV_W-1:0] cnt;
    logic             adv;        // advance fires on this edge
    logic             eff_dir;    // direction used for the wrap search
    logic [LOC_W:0]   r_wrapscan;
    logic [LOC_W-1:0] nxt_loc;
    logic             nxt_wrap;
    logic             load_ok;
`ifdef TILE_SCAN_BOUNCE_EN
    logic             bdir;
    logic             bdir_flip;
    logic [LOC_W:0]   r_fwd;
    logic [LOC_W:0]   r_back;
`endif

    // Load wins over the advance, and pause/!enable suppress it.
    assign adv     = enable && !pause && !load && (cnt == '0);
    assign load_ok = ({1'b0, load_loc} < (LOC_W+1)'(NUM_TILES));

    // ---------------------------------------------------------------
    // Next location selection
    // ---------------------------------------------------------------
    always_comb begin
`ifdef TILE_SCAN_BOUNCE_EN
        eff_dir    = bounce ? bdir : dir;
`else
        eff_dir    = dir;
`endif
        r_wrapscan = scan(location_out, skip_mask, eff_dir, 1'b0);
        nxt_loc    = location_out;
        nxt_wrap   = 1'b0;
`ifdef TILE_SCAN_BOUNCE_EN
        r_fwd      = scan(location_out, skip_mask, bdir, 1'b1);
        r_back     = scan(location_out, skip_mask, ~bdir, 1'b1);
        bdir_flip  = 1'b0;
        if (bounce) begin
            // Nothing left ahead: turn around and take the nearest tile
            // behind. If nothing is there either, stay put. Never wraps.
            if (r_fwd[LOC_W]) begin
                nxt_loc = r_fwd[LOC_W-1:0];
            end else begin
                bdir_flip = 1'b1;
                if (r_back[LOC_W])
                    nxt_loc = r_back[LOC_W-1:0];
            end
        end else
`endif
        if (r_wrapscan[LOC_W]) begin
            nxt_loc  = r_wrapscan[LOC_W-1:0];
            nxt_wrap = eff_dir ? (r_wrapscan[LOC_W-1:0] > location_out)
                               : (r_wrapscan[LOC_W-1:0] < location_out);
        end
    end

    // ---------------------------------------------------------------
    // Divider, location and pulse registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= period;
            location_out <= '0;
            tick         <= 1'b0;
            wrap         <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            if (load) begin
                cnt          <= period;
                location_out <= load_ok ? load_loc : '0;
            end else if (!enable) begin
                cnt <= period;
            end else if (pause) begin
                cnt <= cnt;
            end else if (cnt == '0) begin
                // period is only picked up here, so a change lands after
                // the interval already in flight.
                cnt          <= period;
                location_out <= nxt_loc;
                tick         <= 1'b1;
                wrap         <= nxt_wrap;
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
        end
    end

`ifdef TILE_SCAN_BOUNCE_EN
    // Bounce direction tracks dir except while bouncing, where it only
    // changes when an advance hits the end of the reachable tiles.
    always_ff @(posedge clk) begin
        if (reset || load || !bounce)
            bdir <= dir;
        else if (adv && bdir_flip)
            bdir <= ~bdir;
    end

    assign dir_out = bdir;
`else
    assign dir_out = dir;
`endif

endmodule

// File: tb/tb_tile_scanner.sv
// ---------------------------------------------------------------------------
// tb_tile_scanner
//   Randomised and directed stimulus for tile_scanner, compared each cycle
//   against a behavioural model built from elapsed-cycle counting and
//   modulo tile search. Build with TILE_SCAN_BOUNCE_EN to cover bounce.
// ---------------------------------------------------------------------------
module tb_tile_scanner;
    localparam int NT = 9;
    localparam int LW = 4;
    localparam int DW = 7;

    logic          clk = 1'b0;
    logic          reset, enable, pause, dir, load, bounce;
    logic [DW-1:0] period;
    logic [NT-1:0] skip_mask;
    logic [LW-1:0] load_loc;
    logic [LW-1:0] location_out;
    logic          tick, wrap, dir_out;

    always #5 clk = ~clk;

    tile_scanner #(.NUM_TILES(NT), .LOC_W(LW), .DIV_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .pause        (pause),
        .period       (period),
        .dir          (dir),
        .skip_mask    (skip_mask),
        .load         (load),
        .load_loc     (load_loc),
`ifdef TILE_SCAN_BOUNCE_EN
        .bounce       (bounce),
`endif
        .location_out (location_out),
        .tick         (tick),
        .wrap         (wrap),
        .dir_out      (dir_out)
    );

    int errors = 0;
    int checks = 0;

    // model state
    int m_loc, m_el, m_plen;
    bit m_tick, m_wrap, m_bdir;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_masked(input logic [NT-1:0] m, input int t);
        return (m & (NT'(1) << t)) != '0;
    endfunction

    // Wrap-mode next tile: first unmasked among loc+-1 .. loc+-(NT-1) mod NT.
    function automatic int next_wrap(input int loc, input logic [NT-1:0] m, input bit desc);
        int t;
        for (int k = 1; k < NT; k++) begin
            t = desc ? (loc + NT - k) % NT : (loc + k) % NT;
            if (!is_masked(m, t)) return t;
        end
        return -1;
    endfunction

    // Edge-bounded search: nearest unmasked tile strictly beyond loc.
    function automatic int next_edge(input int loc, input logic [NT-1:0] m, input bit desc);
        if (desc) begin
            for (int t = loc - 1; t >= 0; t--) if (!is_masked(m, t)) return t;
        end else begin
            for (int t = loc + 1; t < NT; t++) if (!is_masked(m, t)) return t;
        end
        return -1;
    endfunction

    task automatic do_advance();
        int n;
        bit d;
        m_tick = 1'b1;
`ifdef TILE_SCAN_BOUNCE_EN
        if (bounce) begin
            n = next_edge(m_loc, skip_mask, m_bdir);
            if (n < 0) begin
                m_bdir = ~m_bdir;
                n = next_edge(m_loc, skip_mask, m_bdir);
            end
            if (n >= 0) m_loc = n;
            return;
        end
`endif
        d = dir;
        n = next_wrap(m_loc, skip_mask, d);
        if (n >= 0) begin
            m_wrap = d ? (n > m_loc) : (n < m_loc);
            m_loc  = n;
        end
    endtask

    // One rising edge worth of behaviour, using the inputs now applied.
    task automatic model_step();
        if (reset) begin
            m_loc = 0; m_tick = 0; m_wrap = 0;
            m_el = 0; m_plen = int'(period); m_bdir = dir;
        end else begin
            m_tick = 0; m_wrap = 0;
            if (load) begin
                m_loc  = (int'(load_loc) < NT) ? int'(load_loc) : 0;
                m_el   = 0; m_plen = int'(period);
            end else if (!enable) begin
                m_el = 0; m_plen = int'(period);
            end else if (pause) begin
                // frozen
            end else if (m_el == m_plen) begin
                do_advance();
                m_el = 0; m_plen = int'(period);
            end else begin
                m_el++;
            end
            if (load || !bounce) m_bdir = dir;
        end
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(negedge clk);
            chk("loc",  32'(location_out), m_loc);
            chk("tick", 32'(tick), 32'(m_tick));
            chk("wrap", 32'(wrap), 32'(m_wrap));
`ifdef TILE_SCAN_BOUNCE_EN
            chk("dir_out", 32'(dir_out), 32'(m_bdir));
`else
            chk("dir_out", 32'(dir_out), 32'(dir));
`endif
        end
    endtask

    initial begin
        reset = 1; enable = 0; pause = 0; period = 3; dir = 0;
        skip_mask = '0; load = 0; load_loc = '0; bounce = 0;
        cycle(2);
        // free run
        reset = 0; enable = 1;
        cycle(40);
        // skip mask, both directions
        skip_mask = 9'b000100110;
        cycle(30);
        dir = 1;
        cycle(30);
        // pause mid-interval
        skip_mask = '0; dir = 0;
        cycle(2);
        pause = 1; cycle(5); pause = 0;
        cycle(10);
        // out-of-range load
        load = 1; load_loc = 4'd12;
        cycle(1);
        load = 0;
        chk("load_oob", 32'(location_out), 32'd0);
        chk("load_tick", 32'(tick), 32'd0);
        cycle(8);
        // degenerate masks
        skip_mask = ~(NT'(1) << 5);
        load = 1; load_loc = 4'd5; cycle(1); load = 0;
        cycle(12);
        chk("lone_tile", 32'(location_out), 32'd5);
        skip_mask = '1;
        cycle(8);
        // period change mid-interval, then reset mid-interval
        skip_mask = '0;
        cycle(2);
        period = 0;
        cycle(8);
        period = 3;
        cycle(6);
        reset = 1; cycle(1); reset = 0;
        chk("rst_loc", 32'(location_out), 32'd0);
        cycle(6);
`ifdef TILE_SCAN_BOUNCE_EN
        bounce = 1; period = 0;
        load = 1; load_loc = '0; cycle(1); load = 0;
        cycle(25);
        bounce = 0;
`endif
        // random
        for (int i = 0; i < 800; i++) begin
            reset  = ($urandom_range(0, 99) == 0);
            load   = ($urandom_range(0, 15) == 0);
            load_loc = LW'($urandom_range(0, 15));
            pause  = ($urandom_range(0, 7) == 0);
            enable = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            if ($urandom_range(0, 19) == 0)
                skip_mask = NT'($urandom) & NT'($urandom);
            if ($urandom_range(0, 19) == 0)
                period = DW'($urandom_range(0, 4));
`ifdef TILE_SCAN_BOUNCE_EN
            if ($urandom_range(0, 29) == 0) bounce = ~bounce;
`endif
            cycle(1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
